// File: rtl/regfile_pkg.sv
// Shared constants and types for the architectural integer register file.
package regfile_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;

    typedef logic [4:0]      reg_addr_t;
    typedef logic [XLEN-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array lookup, same-cycle write bypass and x0 masking.
// REGFILE_X0_HARDWIRE_EN: when defined, address 0 always reads 0 and never bypasses.
import regfile_pkg::*;

module regfile_read_port #(
    parameter int WIDTH   = XLEN - 1,
    parameter int A_WIDTH = $clog2(NREGS) - 1
) (
    input  logic [2**(A_WIDTH+1)-1:0][WIDTH:0] array,
    input  logic [A_WIDTH:0]                   address,
    input  logic [A_WIDTH:0]                   wraddress,
    input  logic [WIDTH:0]                     wdata,
    input  logic                               we,
    output logic [WIDTH:0]                     data
);

    // Stored value, overridden by write data on an address match.
    always_comb begin
        data = array[address];
        if (we && (wraddress == address)) begin
            data = wdata;
        end
`ifdef REGFILE_X0_HARDWIRE_EN
        if (address == '0) begin
            data = '0;
        end
`endif
    end

endmodule

// File: rtl/register_file.sv
// Architectural integer register file: two asynchronous read ports with
// write-through bypass, one synchronous write port fed by the commit stage.
// REGFILE_X0_HARDWIRE_EN: when defined, register 0 is hardwired to zero.
import regfile_pkg::*;

module register_file #(
    parameter int WIDTH   = XLEN - 1,
    parameter int A_WIDTH = $clog2(NREGS) - 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [A_WIDTH:0]   address1,
    input  logic [A_WIDTH:0]   address2,
    input  logic [A_WIDTH:0]   wraddress,
    input  logic [WIDTH:0]     wdata,
    input  logic               regWrite,
    input  logic               validCommit,
    output logic [WIDTH:0]     regValue1,
    output logic [WIDTH:0]     regValue2
);

    localparam int unsigned DEPTH = 2**(A_WIDTH+1);

    logic [DEPTH-1:0][WIDTH:0] regs;
    logic                      we;
    logic                      we_store;

    // Reset gates the enable so the bypass is inert while reset_n is low.
    always_comb begin
        we = regWrite & validCommit & reset_n;
`ifdef REGFILE_X0_HARDWIRE_EN
        we_store = we & (wraddress != '0);
`else
        we_store = we;
`endif
    end

    // Flop-based storage with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '0;
        end else if (we_store) begin
            regs[wraddress] <= wdata;
        end
    end

    regfile_read_port #(.WIDTH(WIDTH), .A_WIDTH(A_WIDTH)) u_port1 (
        .array     (regs),
        .address   (address1),
        .wraddress (wraddress),
        .wdata     (wdata),
        .we        (we),
        .data      (regValue1)
    );

    regfile_read_port #(.WIDTH(WIDTH), .A_WIDTH(A_WIDTH)) u_port2 (
        .array     (regs),
        .address   (address2),
        .wraddress (wraddress),
        .wdata     (wdata),
        .we        (we),
        .data      (regValue2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases plus randomized
// traffic against an array-based reference model.
import regfile_pkg::*;

module tb_register_file;

    logic      clk;
    logic      reset_n;
    reg_addr_t address1;
    reg_addr_t address2;
    reg_addr_t wraddress;
    reg_data_t wdata;
    logic      regWrite;
    logic      validCommit;
    reg_data_t regValue1;
    reg_data_t regValue2;

    reg_data_t ref_regs [NREGS];
    int        checks;
    int        errors;

    register_file dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address1    (address1),
        .address2    (address2),
        .wraddress   (wraddress),
        .wdata       (wdata),
        .regWrite    (regWrite),
        .validCommit (validCommit),
        .regValue1   (regValue1),
        .regValue2   (regValue2)
    );

    // 5-unit clock period; rising edge followed 2 units later by the falling edge.
    initial begin
        clk = 1'b0;
        forever begin
            #3 clk = 1'b1;
            #2 clk = 1'b0;
        end
    end

    task automatic check(input string tag, input reg_data_t got, input reg_data_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit x0_hardwired();
`ifdef REGFILE_X0_HARDWIRE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Value architecturally visible on a read port right now.
    function automatic reg_data_t expect_read(input reg_addr_t addr);
        if (!reset_n) return '0;
        if (x0_hardwired() && addr == 0) return '0;
        if (regWrite && validCommit && addr == wraddress) return wdata;
        return ref_regs[addr];
    endfunction

    task automatic check_ports(input string tag);
        check({tag, "_p1"}, regValue1, expect_read(address1));
        check({tag, "_p2"}, regValue2, expect_read(address2));
    endtask

    // Advance across one rising edge, committing the write the model expects,
    // then settle 1 unit past the edge.
    task automatic tick();
        @(posedge clk);
        if (reset_n && regWrite && validCommit && !(x0_hardwired() && wraddress == 0))
            ref_regs[wraddress] = wdata;
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) ref_regs[i] = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_clear();
        reset_n     = 1'b0;
        regWrite    = 1'b1;
        validCommit = 1'b1;
        wraddress   = 5'd9;
        wdata       = 32'hDEAD_BEEF;
        address1    = 5'd9;
        address2    = 5'd17;
        #1;
        check("rst_p1", regValue1, '0);
        check("rst_p2", regValue2, '0);
        tick();
        check("rst_edge_p1", regValue1, '0);
        check("rst_edge_p2", regValue2, '0);
        regWrite = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            address1 = 5'(i);
            address2 = 5'(NREGS - 1 - i);
            #1;
            check("post_rst_p1", regValue1, '0);
            check("post_rst_p2", regValue2, '0);
        end
        tick();

        // Same-cycle bypass on write of 5 to x2.
        regWrite = 1'b1; validCommit = 1'b1;
        wraddress = 5'd2; wdata = 32'd5; address1 = 5'd2; address2 = 5'd7;
        #1;
        check("bypass_x2", regValue1, 32'd5);
        tick();

        // Next cycle: write 6 to x3, read stored x2 on port 2.
        wraddress = 5'd3; wdata = 32'd6; address1 = 5'd3; address2 = 5'd2;
        #1;
        check("stored_x2", regValue2, 32'd5);
        check("bypass_x3", regValue1, 32'd6);
        tick();

        // Mid-cycle wdata change with enable dropped must not touch x3.
        wdata = 32'd30; regWrite = 1'b0; address1 = 5'd3;
        #1;
        check("x3_hold_pre", regValue1, 32'd6);
        tick();
        check("x3_hold_post", regValue1, 32'd6);

        // Gating: either enable low means no write and no bypass.
        regWrite = 1'b1; validCommit = 1'b0; wraddress = 5'd4; wdata = 32'd9; address1 = 5'd4;
        #1;
        check("gate_vc_pre", regValue1, 32'd0);
        tick();
        check("gate_vc_post", regValue1, 32'd0);
        regWrite = 1'b0; validCommit = 1'b1;
        #1;
        check("gate_rw_pre", regValue1, 32'd0);
        tick();
        check("gate_rw_post", regValue1, 32'd0);

        // x0 write of 7.
        regWrite = 1'b1; validCommit = 1'b1; wraddress = 5'd0; wdata = 32'd7;
        address1 = 5'd0; address2 = 5'd0;
        #1;
        check("x0_pre_p1", regValue1, x0_hardwired() ? 32'd0 : 32'd7);
        check("x0_pre_p2", regValue2, x0_hardwired() ? 32'd0 : 32'd7);
        tick();
        regWrite = 1'b0;
        #1;
        check("x0_post_p1", regValue1, x0_hardwired() ? 32'd0 : 32'd7);
        check("x0_post_p2", regValue2, x0_hardwired() ? 32'd0 : 32'd7);
        tick();

        // Randomized traffic with occasional mid-cycle changes and async resets.
        for (int n = 0; n < 600; n++) begin
            address1    = 5'($urandom_range(NREGS - 1));
            address2    = ($urandom_range(7) == 0) ? address1 : 5'($urandom_range(NREGS - 1));
            wraddress   = ($urandom_range(3) == 0) ? address1 : 5'($urandom_range(NREGS - 1));
            wdata       = $urandom;
            regWrite    = ($urandom_range(3) != 0);
            validCommit = ($urandom_range(3) != 0);
            #1;
            check_ports("rnd");
            if ($urandom_range(5) == 0) begin
                wdata    = $urandom;
                regWrite = $urandom_range(1) == 1;
                #1;
                check_ports("rnd_mid");
            end
            if (n % 97 == 50) begin
                reset_n = 1'b0;
                model_clear();
                #1;
                check_ports("async_rst");
                check("async_rst_p1_zero", regValue1, '0);
                tick();
                check_ports("rst_held");
                reset_n = 1'b1;
                #1;
                check_ports("rst_release");
            end
            tick();
            // Read back the register that was just targeted.
            address1 = wraddress;
            regWrite = 1'b0;
            #1;
            check_ports("rnd_readback");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
